amp_i2c_arbiter: RTL and testbench

//  Shares one byte-level amp I2C write engine between NREQ requesters (boot config, volume, status poll).

---
 rtl/amp_i2c_arbiter_pkg.sv | 22 ++
 rtl/amp_i2c_arbiter_rr_pick.sv | 39 +++
 rtl/amp_i2c_arbiter.sv | 175 +++++++++++++++++
 tb/tb_amp_i2c_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/amp_i2c_arbiter_pkg.sv
// Shared definitions for the amp I2C write arbiter: FSM state encoding, response codes and defaults.
// Default GAP/TMO values are shared with amp_i2c_master.
package amp_i2c_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4,
    ST_HOLD  = 3'd5
  } arb_state_e;

  // rsp_err code meaning: RSP_ERR flags a NACK or an engine timeout
  localparam logic RSP_OK  = 1'b0;
  localparam logic RSP_ERR = 1'b1;

  localparam int DEF_GAP = 8;
  localparam int DEF_TMO = 4095;
  localparam int TMO_W   = 12;

endpackage

// File: rtl/amp_i2c_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping at NREQ.
module amp_i2c_arbiter_rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  logic [2:0]      ptr,
  output logic [2:0]      grant_idx,
  output logic            any_valid
);

  logic [7:0] req_pad_s;
  logic [3:0] cand_s;
  logic [2:0] idx_s;

  // Scan from the farthest offset down so the nearest request to ptr wins last.
  always_comb begin
    req_pad_s = 8'd0;
    req_pad_s[NREQ-1:0] = req;
    idx_s = 3'd0;
    cand_s = 4'd0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand_s = {1'b0, ptr} + 4'(k);
      if (cand_s >= 4'(NREQ)) begin
        cand_s = cand_s - 4'(NREQ);
      end else begin
        cand_s = cand_s;
      end
      if (req_pad_s[cand_s[2:0]]) begin
        idx_s = cand_s[2:0];
      end else begin
        idx_s = idx_s;
      end
    end
  end

  assign grant_idx = idx_s;
  assign any_valid = |req;

endmodule

// File: rtl/amp_i2c_arbiter.sv
// Round-robin arbiter sharing one amp I2C register-write engine between NREQ requesters.
// Optional engine watchdog: define AMP_I2C_ARB_TIMEOUT_EN (adds parameter TMO).
module amp_i2c_arbiter
  import amp_i2c_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int GAP  = DEF_GAP
`ifdef AMP_I2C_ARB_TIMEOUT_EN
  ,
  parameter int TMO  = DEF_TMO
`endif
) (
  input  logic              clk_in,
  input  logic              resetb,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*8-1:0] req_addr,
  input  logic [NREQ*8-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic              rsp_err,
  output logic [2:0]        grant_id,
  output logic              eng_start,
  output logic [7:0]        eng_addr,
  output logic [7:0]        eng_data,
  input  logic              eng_busy,
  input  logic              eng_done,
  input  logic              eng_nack
);

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  arb_state_e      state_r;
  logic [2:0]      rr_ptr_r;
  logic [GW-1:0]   gap_r;
  logic [NREQ-1:0] req_ready_r;
  logic [NREQ-1:0] rsp_valid_r;
  logic            rsp_err_r;
  logic [2:0]      grant_id_r;
  logic            eng_start_r;
  logic [7:0]      eng_addr_r;
  logic [7:0]      eng_data_r;
`ifdef AMP_I2C_ARB_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt_r;
`endif

  logic [2:0] pick_s;
  logic       any_s;
  logic [7:0] addr_sel_s;
  logic [7:0] data_sel_s;

  amp_i2c_arbiter_rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .req       (req_valid),
    .ptr       (rr_ptr_r),
    .grant_idx (pick_s),
    .any_valid (any_s)
  );

  // Payload of the requester the picker currently selects.
  always_comb begin
    addr_sel_s = 8'd0;
    data_sel_s = 8'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_s == 3'(i)) begin
        addr_sel_s = req_addr[8*i +: 8];
        data_sel_s = req_data[8*i +: 8];
      end else begin
        addr_sel_s = addr_sel_s;
        data_sel_s = data_sel_s;
      end
    end
  end

  // Arbiter FSM; every output is a register so each pulse lines up with its state.
  always_ff @(posedge clk_in or negedge resetb) begin
    if (!resetb) begin
      state_r     <= ST_IDLE;
      rr_ptr_r    <= 3'd0;
      gap_r       <= {GW{1'b0}};
      req_ready_r <= {NREQ{1'b0}};
      rsp_valid_r <= {NREQ{1'b0}};
      rsp_err_r   <= RSP_OK;
      grant_id_r  <= 3'd0;
      eng_start_r <= 1'b0;
      eng_addr_r  <= 8'd0;
      eng_data_r  <= 8'd0;
`ifdef AMP_I2C_ARB_TIMEOUT_EN
      tmo_cnt_r   <= {TMO_W{1'b0}};
`endif
    end else begin
      req_ready_r <= {NREQ{1'b0}};
      rsp_valid_r <= {NREQ{1'b0}};
      rsp_err_r   <= RSP_OK;
      eng_start_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (any_s) begin
            for (int i = 0; i < NREQ; i++) begin
              req_ready_r[i] <= (pick_s == 3'(i));
            end
            eng_addr_r <= addr_sel_s;
            eng_data_r <= data_sel_s;
            grant_id_r <= pick_s;
            rr_ptr_r   <= (pick_s == 3'(NREQ - 1)) ? 3'd0 : pick_s + 3'd1;
            state_r    <= ST_GRANT;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        // The grant cycle already checks the engine so an idle engine starts right after req_ready.
        ST_GRANT, ST_ISSUE: begin
          if (!eng_busy) begin
            eng_start_r <= 1'b1;
`ifdef AMP_I2C_ARB_TIMEOUT_EN
            tmo_cnt_r   <= {TMO_W{1'b0}};
`endif
            state_r     <= ST_WAIT;
          end else begin
            state_r <= ST_ISSUE;
          end
        end
        ST_WAIT: begin
          if (eng_done) begin
            for (int i = 0; i < NREQ; i++) begin
              rsp_valid_r[i] <= (grant_id_r == 3'(i));
            end
            rsp_err_r <= eng_nack;
            state_r   <= ST_RESP;
          end
`ifdef AMP_I2C_ARB_TIMEOUT_EN
          else if (tmo_cnt_r == TMO_W'(TMO - 1)) begin
            for (int i = 0; i < NREQ; i++) begin
              rsp_valid_r[i] <= (grant_id_r == 3'(i));
            end
            rsp_err_r <= RSP_ERR;
            state_r   <= ST_RESP;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + 12'd1;
            state_r   <= ST_WAIT;
          end
`else
          else begin
            state_r <= ST_WAIT;
          end
`endif
        end
        ST_RESP: begin
          gap_r   <= GW'(GAP - 1);
          state_r <= ST_HOLD;
        end
        ST_HOLD: begin
          if (gap_r == {GW{1'b0}}) begin
            state_r <= ST_IDLE;
          end else begin
            gap_r   <= gap_r - GW'(1);
            state_r <= ST_HOLD;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_err   = rsp_err_r;
  assign grant_id  = grant_id_r;
  assign eng_start = eng_start_r;
  assign eng_addr  = eng_addr_r;
  assign eng_data  = eng_data_r;

endmodule

// File: tb/tb_amp_i2c_arbiter.sv
// Self-checking bench for amp_i2c_arbiter: timeline model plus directed literal checks.
module tb_amp_i2c_arbiter;

  localparam int NREQ_TB = 4;
  localparam int GAP_TB  = 8;
`ifdef AMP_I2C_ARB_TIMEOUT_EN
  localparam int TMO_TB  = 100;
`endif

  localparam int M_IDLE  = 0;
  localparam int M_ISSUE = 1;
  localparam int M_WAIT  = 2;
  localparam int M_GAP   = 3;

  logic        clk_in;
  logic        resetb = 1'b0;
  logic [3:0]  req_valid = 4'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_data = 32'd0;
  logic [3:0]  req_ready;
  logic [3:0]  rsp_valid;
  logic        rsp_err;
  logic [2:0]  grant_id;
  logic        eng_start;
  logic [7:0]  eng_addr;
  logic [7:0]  eng_data;
  logic        eng_busy = 1'b0;
  logic        eng_done = 1'b0;
  logic        eng_nack = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_done_cyc = 0;
  int eng_lat = 5;
  bit eng_mute = 1'b0;
  bit nack_cfg = 1'b0;

  logic [3:0] exp_ready = 4'd0;
  logic [3:0] exp_rsp = 4'd0;
  logic       exp_err = 1'b0;
  logic [2:0] exp_gid = 3'd0;
  logic       exp_start = 1'b0;
  logic [7:0] exp_addr = 8'd0;
  logic [7:0] exp_data = 8'd0;

  amp_i2c_arbiter #(
    .NREQ (NREQ_TB),
    .GAP  (GAP_TB)
`ifdef AMP_I2C_ARB_TIMEOUT_EN
    ,
    .TMO  (TMO_TB)
`endif
  ) dut (
    .clk_in    (clk_in),
    .resetb    (resetb),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .grant_id  (grant_id),
    .eng_start (eng_start),
    .eng_addr  (eng_addr),
    .eng_data  (eng_data),
    .eng_busy  (eng_busy),
    .eng_done  (eng_done),
    .eng_nack  (eng_nack)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int rr_first(input logic [3:0] v, input int from);
    for (int k = 0; k < NREQ_TB; k++) begin
      if (v[(from + k) % NREQ_TB]) return (from + k) % NREQ_TB;
    end
    return -1;
  endfunction

  function automatic int oh2i(input logic [3:0] v);
    for (int i = 0; i < NREQ_TB; i++) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // Engine stand-in: answers eng_done eng_lat cycles after each start.
  initial begin : engine_bfm
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk_in);
      #1;
      eng_done = 1'b0;
      eng_nack = 1'b0;
      if (!resetb) begin
        cnt = 0;
      end else if (eng_start && !eng_mute) begin
        cnt = eng_lat;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          eng_done = 1'b1;
          eng_nack = nack_cfg;
        end
      end
    end
  end

  // Timeline model: which outputs must be seen after each rising edge.
  initial begin : model
    int ph, g, ptr, gap_left, wait_edges;
    ph = M_IDLE; g = 0; ptr = 0; gap_left = 0; wait_edges = 0;
    forever begin
      @(posedge clk_in);
      cyc++;
      exp_ready = 4'd0;
      exp_rsp = 4'd0;
      exp_err = 1'b0;
      exp_start = 1'b0;
      if (!resetb) begin
        ph = M_IDLE; ptr = 0; g = 0;
        exp_gid = 3'd0; exp_addr = 8'd0; exp_data = 8'd0;
      end else if (ph == M_IDLE) begin
        if (req_valid != 4'd0) begin
          g = rr_first(req_valid, ptr);
          exp_ready = 4'd1 << g;
          exp_gid = 3'(g);
          exp_addr = req_addr[8*g +: 8];
          exp_data = req_data[8*g +: 8];
          ptr = (g + 1) % NREQ_TB;
          ph = M_ISSUE;
        end
      end else if (ph == M_ISSUE) begin
        if (!eng_busy) begin
          exp_start = 1'b1;
          wait_edges = 0;
          ph = M_WAIT;
        end
      end else if (ph == M_WAIT) begin
        wait_edges++;
        if (eng_done) begin
          exp_rsp = 4'd1 << g;
          exp_err = eng_nack;
          gap_left = 1 + GAP_TB;  // response cycle, then GAP bus-free cycles
          ph = M_GAP;
        end
`ifdef AMP_I2C_ARB_TIMEOUT_EN
        else if (wait_edges == TMO_TB) begin
          exp_rsp = 4'd1 << g;
          exp_err = 1'b1;
          gap_left = 1 + GAP_TB;
          ph = M_GAP;
        end
`endif
      end else begin
        gap_left--;
        if (gap_left == 0) ph = M_IDLE;
      end
    end
  end

  // Every-cycle comparison against the model; reset forces all outputs to zero.
  initial begin : compare
    forever begin
      @(negedge clk_in);
      if (eng_done) last_done_cyc = cyc;
      chk("req_ready", 32'(req_ready), resetb ? 32'(exp_ready) : 32'd0);
      chk("rsp_valid", 32'(rsp_valid), resetb ? 32'(exp_rsp) : 32'd0);
      if (resetb && exp_rsp != 4'd0) chk("rsp_err", 32'(rsp_err), 32'(exp_err));
      chk("grant_id", 32'(grant_id), resetb ? 32'(exp_gid) : 32'd0);
      chk("eng_start", 32'(eng_start), resetb ? 32'(exp_start) : 32'd0);
      chk("eng_addr", 32'(eng_addr), resetb ? 32'(exp_addr) : 32'd0);
      chk("eng_data", 32'(eng_data), resetb ? 32'(exp_data) : 32'd0);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic do_reset();
    req_valid = 4'd0;
    resetb = 1'b0;
    tick(3);
    resetb = 1'b1;
  endtask

  task automatic wait_ready(input int bound);
    int n;
    n = 0;
    do begin
      tick(1);
      n++;
    end while (req_ready == 4'd0 && n < bound);
    chk("ready_seen", 32'(|req_ready), 32'd1);
  endtask

  task automatic wait_start(input int bound);
    int n;
    n = 0;
    do begin
      tick(1);
      n++;
    end while (!eng_start && n < bound);
    chk("start_seen", 32'(eng_start), 32'd1);
  endtask

  task automatic wait_rsp(input int bound);
    int n;
    n = 0;
    do begin
      tick(1);
      n++;
    end while (rsp_valid == 4'd0 && n < bound);
    chk("rsp_seen", 32'(|rsp_valid), 32'd1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int order [5];
    int exp_order [5];
    int start_cyc;
    exp_order = '{0, 1, 2, 3, 0};
    req_addr = {8'h43, 8'h42, 8'h41, 8'h40};
    req_data = {8'h2B, 8'h2A, 8'h19, 8'h18};
    do_reset();
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd0);
    chk("rst_addr", 32'(eng_addr), 32'd0);

    // 1: single write from requester 0
    req_valid = 4'b0001;
    wait_ready(20);
    chk("t1_ready", 32'(req_ready), 32'h1);
    req_valid = 4'b0000;
    tick(1);
    chk("t1_start", 32'(eng_start), 32'd1);
    chk("t1_addr", 32'(eng_addr), 32'h40);
    chk("t1_data", 32'(eng_data), 32'h18);
    wait_rsp(50);
    chk("t1_rsp", 32'(rsp_valid), 32'h1);
    chk("t1_err", 32'(rsp_err), 32'd0);
    tick(15);

    // 2: all requesters held, 20-cycle engine
    do_reset();
    eng_lat = 20;
    req_valid = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_ready(200);
      order[n] = oh2i(req_ready);
      if (n > 0) chk("t2_gap", (cyc - last_done_cyc - 1 >= GAP_TB) ? 32'd1 : 32'd0, 32'd1);
      if (n == 4) req_valid = 4'b0000;
    end
    for (int n = 0; n < 5; n++) chk("t2_order", 32'(order[n]), 32'(exp_order[n]));
    wait_rsp(100);
    tick(15);

    // 3: engine busy for 10 cycles after the grant
    eng_lat = 4;
    eng_busy = 1'b1;
    req_valid = 4'b0010;
    wait_ready(20);
    chk("t3_ready", 32'(req_ready), 32'h2);
    req_valid = 4'b0000;
    for (int n = 0; n < 10; n++) begin
      tick(1);
      chk("t3_no_start", 32'(eng_start), 32'd0);
    end
    eng_busy = 1'b0;
    tick(1);
    chk("t3_start", 32'(eng_start), 32'd1);
    chk("t3_addr", 32'(eng_addr), 32'h41);
    wait_rsp(50);
    tick(15);

    // 4: NACK on requester 2, pointer then sits at 3
    nack_cfg = 1'b1;
    req_valid = 4'b0100;
    wait_ready(20);
    req_valid = 4'b0000;
    wait_rsp(50);
    chk("t4_rsp", 32'(rsp_valid), 32'h4);
    chk("t4_err", 32'(rsp_err), 32'd1);
    nack_cfg = 1'b0;
    eng_lat = 30;
    req_valid = 4'b1001;
    wait_ready(30);
    chk("t4_next", 32'(req_ready), 32'h8);
    chk("t4_gid", 32'(grant_id), 32'd3);
    req_valid = 4'b0001;

    // 6: reset while waiting on the engine, req0 still pending
    wait_start(20);
    tick(5);
    resetb = 1'b0;
    #1;
    chk("t6_ready", 32'(req_ready), 32'd0);
    chk("t6_rsp", 32'(rsp_valid), 32'd0);
    chk("t6_gid", 32'(grant_id), 32'd0);
    chk("t6_addr", 32'(eng_addr), 32'd0);
    chk("t6_data", 32'(eng_data), 32'd0);
    tick(3);
    resetb = 1'b1;
    eng_lat = 5;
    wait_ready(20);
    chk("t6_regrant", 32'(req_ready), 32'h1);
    req_valid = 4'b0000;
    wait_rsp(50);
    chk("t6_rsp0", 32'(rsp_valid), 32'h1);
    tick(15);

`ifdef AMP_I2C_ARB_TIMEOUT_EN
    // 5: engine never answers, watchdog responds with an error
    eng_mute = 1'b1;
    req_valid = 4'b0010;
    wait_ready(20);
    req_valid = 4'b0000;
    wait_start(20);
    start_cyc = cyc;
    wait_rsp(TMO_TB + 50);
    chk("t5_err", 32'(rsp_err), 32'd1);
    chk("t5_lat", 32'(cyc - start_cyc), 32'(TMO_TB));
    eng_mute = 1'b0;
    req_valid = 4'b0100;
    wait_ready(30);
    chk("t5_next", 32'(req_ready), 32'h4);
    req_valid = 4'b0000;
    wait_rsp(50);
    tick(15);
`else
    start_cyc = 0;
    eng_mute = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
